// File: rtl/outlier_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lidar_wb_pkg
// Description : Shared constants and FSM state encoding for the outlier
//               write-back stage and its address-mapping helper.
//               Contents: default geometry (lane width, bus width, lanes per
//               word, header words, byte-enable width) and the write-back
//               FSM state codes.
//               Optional build macro used by the stage: WB_COALESCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package lidar_wb_pkg;

  // Default geometry of the packed point BRAM.
  localparam int WB_N            = 16;                 // bits per lane (one coordinate)
  localparam int WB_BUS_SIZE     = 32;                 // BRAM data width
  localparam int WB_LANES        = WB_BUS_SIZE / WB_N; // points per BRAM word
  localparam int WB_HEADER_WORDS = 2;                  // header words ahead of point data
  localparam int WB_MASK_W       = WB_BUS_SIZE / 8;    // byte-enable (lane mask) width
  localparam int WB_BRAM_SHIFT   = 2;                  // byte-address shift per word
  localparam int WB_IDX_W        = 16;                 // outlier index width
  localparam int WB_CNT_W        = 32;                 // outlier counter width

  // Write-back FSM state encoding.
  typedef logic [2:0] wb_state_t;

  localparam wb_state_t ST_IDLE   = 3'd0;
  localparam wb_state_t ST_DRAIN  = 3'd1;
  localparam wb_state_t ST_FLUSH  = 3'd2;
  localparam wb_state_t ST_STATUS = 3'd3;
  localparam wb_state_t ST_DONE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/outlier_writeback_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : outlier_addr_map
// Description : Combinational point-index mapper. Converts a point index into
//               the byte address of the packed BRAM word holding it, the
//               byte-enable mask selecting its lane, and an accept flag.
//               Index 0 is reserved padding and indices at or beyond the
//               point-cloud size are out of range; both are rejected.
// Ports       : idx              in  IDX_W          point index
//               point_cloud_size in  32             number of valid points
//               addr             out 32             word byte address
//               mask             out BUS_SIZE/8     lane byte-enable mask
//               accept           out 1              index is a real point
// Revision    : 1.0 - initial release
// ============================================================================
module outlier_addr_map
  import lidar_wb_pkg::*;
#(
  parameter int N            = WB_N,
  parameter int BUS_SIZE     = WB_BUS_SIZE,
  parameter int BRAM_SHIFT   = WB_BRAM_SHIFT,
  parameter int HEADER_WORDS = WB_HEADER_WORDS,
  parameter int IDX_W        = WB_IDX_W
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           point_cloud_size,
  output logic [31:0]           addr,
  output logic [BUS_SIZE/8-1:0] mask,
  output logic                  accept
);

  localparam int LANES      = BUS_SIZE / N;
  localparam int LANE_BYTES = N / 8;

  logic [31:0] idx_ext;
  logic [31:0] word;
  logic [31:0] lane;

  always_comb begin
    idx_ext = 32'(idx);
    word    = 32'(HEADER_WORDS) + (idx_ext / 32'(LANES));
    lane    = idx_ext % 32'(LANES);
    addr    = word << BRAM_SHIFT;
    accept  = (idx_ext != 32'd0) && (idx_ext < point_cloud_size);
  end

  // Each lane owns LANE_BYTES contiguous byte enables; only the selected
  // lane's group is set.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign mask[l*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{lane == 32'(l)}};
  end

endmodule
`default_nettype wire

// File: rtl/outlier_writeback.sv
`default_nettype none
// ============================================================================
// Module      : outlier_writeback
// Description : Drains outlier point indices from a first-word-fall-through
//               FIFO, zeroes the 16-bit lane of each accepted point in the
//               x BRAM with byte-enables, writes the accepted-outlier count
//               into header word 0 of the z BRAM and pulses done.
//               Build option WB_COALESCE_EN: when defined, adjacent accepted
//               indices that fall into the same BRAM word are merged into a
//               single masked write; when undefined every accepted index
//               issues its own single-lane write one cycle after its pop.
// Ports       : clock            in  1             system clock, rising edge
//               reset_n          in  1             async active-low reset
//               start            in  1             run request pulse
//               point_cloud_size in  32            number of valid points
//               fifo_dout        in  IDX_W         FIFO head (FWFT)
//               fifo_empty       in  1             FIFO empty flag
//               fifo_rd          out 1             FIFO pop strobe
//               addr_x           out 32            x BRAM byte address
//               write_in_x       out BUS_SIZE      x BRAM write data (zero)
//               en_x             out 1             x BRAM enable
//               we_x             out BUS_SIZE/8    x BRAM byte enables
//               addr_z           out 32            z BRAM byte address
//               write_in_z       out BUS_SIZE      z BRAM write data
//               en_z             out 1             z BRAM enable
//               we_z             out BUS_SIZE/8    z BRAM byte enables
//               busy             out 1             run in progress
//               done             out 1             completion pulse
//               outlier_count    out CNT_W         accepted outliers
// Revision    : 1.0 - initial release
// ============================================================================
module outlier_writeback
  import lidar_wb_pkg::*;
#(
  parameter int N            = WB_N,
  parameter int BUS_SIZE     = WB_BUS_SIZE,
  parameter int BRAM_SHIFT   = WB_BRAM_SHIFT,
  parameter int HEADER_WORDS = WB_HEADER_WORDS,
  parameter int IDX_W        = WB_IDX_W,
  parameter int CNT_W        = WB_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           point_cloud_size,
  input  logic [IDX_W-1:0]      fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  output logic [31:0]           addr_x,
  output logic [BUS_SIZE-1:0]   write_in_x,
  output logic                  en_x,
  output logic [BUS_SIZE/8-1:0] we_x,
  output logic [31:0]           addr_z,
  output logic [BUS_SIZE-1:0]   write_in_z,
  output logic                  en_z,
  output logic [BUS_SIZE/8-1:0] we_z,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      outlier_count
);

  localparam int MASK_W = BUS_SIZE / 8;

  // --------------------------------------------------------------------------
  // Index -> {word address, lane mask, accept}
  // --------------------------------------------------------------------------
  logic [31:0]       map_addr;
  logic [MASK_W-1:0] map_mask;
  logic              map_accept;

  outlier_addr_map #(
    .N            (N),
    .BUS_SIZE     (BUS_SIZE),
    .BRAM_SHIFT   (BRAM_SHIFT),
    .HEADER_WORDS (HEADER_WORDS),
    .IDX_W        (IDX_W)
  ) u_addr_map (
    .idx              (fifo_dout),
    .point_cloud_size (point_cloud_size),
    .addr             (map_addr),
    .mask             (map_mask),
    .accept           (map_accept)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wb_state_t         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       addr_x_q, addr_x_d;
  logic              en_x_q, en_x_d;
  logic [MASK_W-1:0] we_x_q, we_x_d;

`ifdef WB_COALESCE_EN
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_addr_q, pend_addr_d;
  logic [MASK_W-1:0] pend_mask_q, pend_mask_d;
`endif

  logic pop;
  assign pop = (state_q == ST_DRAIN) && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_x_d = addr_x_q;   // address holds between writes
    en_x_d   = 1'b0;       // write strobes are single-cycle by default
    we_x_d   = '0;
`ifdef WB_COALESCE_EN
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_mask_d  = pend_mask_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
`ifdef WB_COALESCE_EN
          pend_valid_d = 1'b0;
          pend_mask_d  = '0;
`endif
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (fifo_empty) begin
`ifdef WB_COALESCE_EN
          // Schedule the final pending word so it is written during FLUSH.
          if (pend_valid_q) begin
            en_x_d   = 1'b1;
            we_x_d   = pend_mask_q;
            addr_x_d = pend_addr_q;
          end
          pend_valid_d = 1'b0;
`endif
          state_d = ST_FLUSH;
        end else if (map_accept) begin
          count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
`ifdef WB_COALESCE_EN
          if (pend_valid_q && (map_addr == pend_addr_q)) begin
            pend_mask_d = pend_mask_q | map_mask;
          end else begin
            // New word: evict the old entry next cycle, keep the new one.
            if (pend_valid_q) begin
              en_x_d   = 1'b1;
              we_x_d   = pend_mask_q;
              addr_x_d = pend_addr_q;
            end
            pend_valid_d = 1'b1;
            pend_addr_d  = map_addr;
            pend_mask_d  = map_mask;
          end
`else
          en_x_d   = 1'b1;
          we_x_d   = map_mask;
          addr_x_d = map_addr;
`endif
        end
      end

      ST_FLUSH:  state_d = ST_STATUS;
      ST_STATUS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      addr_x_q <= '0;
      en_x_q   <= 1'b0;
      we_x_q   <= '0;
`ifdef WB_COALESCE_EN
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_mask_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      addr_x_q <= addr_x_d;
      en_x_q   <= en_x_d;
      we_x_q   <= we_x_d;
`ifdef WB_COALESCE_EN
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_mask_q  <= pend_mask_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_rd       = pop;
  assign addr_x        = addr_x_q;
  assign write_in_x    = '0;
  assign en_x          = en_x_q;
  assign we_x          = we_x_q;

  // Status word always lands in header word 0 of the z BRAM.
  assign addr_z        = '0;
  assign en_z          = (state_q == ST_STATUS);
  assign we_z          = {MASK_W{en_z}};
  assign write_in_z    = en_z ? BUS_SIZE'(count_q) : '0;

  assign busy          = (state_q == ST_DRAIN) || (state_q == ST_FLUSH) ||
                         (state_q == ST_STATUS);
  assign done          = (state_q == ST_DONE);
  assign outlier_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_outlier_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_outlier_writeback
// Description : Self-checking bench for outlier_writeback. A queue models the
//               FWFT FIFO; a monitor records x/z BRAM writes, done pulses and
//               busy cycles; a list-level reference model derives the expected
//               write sequence and count from the index stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outlier_writeback;

`ifdef WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] point_cloud_size = 32'd0;
  logic [15:0] fifo_dout = 16'd0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [31:0] addr_x;
  logic [31:0] write_in_x;
  logic        en_x;
  logic [3:0]  we_x;
  logic [31:0] addr_z;
  logic [31:0] write_in_z;
  logic        en_z;
  logic [3:0]  we_z;
  logic        busy;
  logic        done;
  logic [31:0] outlier_count;

  outlier_writeback dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .point_cloud_size (point_cloud_size),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd          (fifo_rd),
    .addr_x           (addr_x),
    .write_in_x       (write_in_x),
    .en_x             (en_x),
    .we_x             (we_x),
    .addr_z           (addr_z),
    .write_in_z       (write_in_z),
    .en_z             (en_z),
    .we_z             (we_z),
    .busy             (busy),
    .done             (done),
    .outlier_count    (outlier_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit capturing = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- FIFO model ----------------
  logic [15:0] fifo_q[$];
  logic [15:0] stim[$];
  bit          rd_seen = 1'b0;

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? 16'd0 : fifo_q[0];
  endtask

  always @(negedge clock) rd_seen = fifo_rd;

  always @(posedge clock) begin
    #1;
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
  end

  // ---------------- monitor ----------------
  logic [31:0] got_addr[$];
  logic [3:0]  got_we[$];
  int          wdata_bad, z_n, z_cyc, done_n, done_cyc, busy_n;
  logic [31:0] z_data, z_addr;
  logic [3:0]  z_we;

  always @(negedge clock) begin
    if (capturing) begin
      if (en_x) begin
        got_addr.push_back(addr_x);
        got_we.push_back(we_x);
        if (write_in_x !== 32'd0) wdata_bad++;
      end
      if (en_z) begin
        z_n++;
        z_cyc  = cyc - start_cyc;
        z_data = write_in_z;
        z_addr = addr_z;
        z_we   = we_z;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc - start_cyc;
      end
      if (busy) busy_n++;
    end
  end

  task automatic clear_logs();
    got_addr.delete();
    got_we.delete();
    wdata_bad = 0; z_n = 0; z_cyc = -1; done_n = 0; done_cyc = -1; busy_n = 0;
    z_data = 32'hx; z_addr = 32'hx; z_we = 4'hx;
  endtask

  // Load stim into the FIFO, pulse start, optionally pulse start again at
  // relative cycle restart_at, and capture until a few cycles after done.
  task automatic run_and_capture(input int size, input int restart_at);
    clear_logs();
    fifo_q = stim;
    refresh_fifo();
    point_cloud_size = size;
    @(posedge clock); #1;
    start = 1'b1;
    start_cyc = cyc;
    capturing = 1'b1;
    for (int k = 1; k <= 400 && done_n == 0; k++) begin
      @(posedge clock); #1;
      start = (k == restart_at);
    end
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    capturing = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_addr[$];
  logic [3:0]  exp_we[$];
  int          exp_count;

  task automatic model(input int size);
    int   word, pword;
    logic [3:0] m, pmask;
    bit   have;
    exp_addr.delete();
    exp_we.delete();
    exp_count = 0;
    have = 1'b0;
    pword = 0;
    pmask = 4'd0;
    foreach (stim[i]) begin
      if (stim[i] != 0 && int'(stim[i]) < size) begin
        exp_count++;
        word = 2 + int'(stim[i]) / 2;
        m = (stim[i] % 2 == 0) ? 4'b0011 : 4'b1100;
        if (!COAL) begin
          exp_addr.push_back(32'(word * 4));
          exp_we.push_back(m);
        end else if (have && word == pword) begin
          pmask = pmask | m;
        end else begin
          if (have) begin
            exp_addr.push_back(32'(pword * 4));
            exp_we.push_back(pmask);
          end
          have = 1'b1;
          pword = word;
          pmask = m;
        end
      end
    end
    if (have) begin
      exp_addr.push_back(32'(pword * 4));
      exp_we.push_back(pmask);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({fifo_rd, addr_x, write_in_x, en_x, we_x, addr_z, write_in_z, en_z, we_z,
         busy, done, outlier_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b en_x=%b en_z=%b done=%b cnt=%0d, all zero required",
               busy, en_x, en_z, done, outlier_count);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_empty();
    stim.delete();
    run_and_capture(100, -1);
    checks++;
    if (got_addr.size() != 0) begin
      errors++; $display("FAIL empty_xwrites: got %0d required 0", got_addr.size());
    end
    checks++;
    if (z_cyc !== 3 || z_addr !== 32'd0 || z_data !== 32'd0 || z_we !== 4'hF) begin
      errors++;
      $display("FAIL empty_zwrite: got cyc=%0d addr=%0h data=%0h we=%b required cyc=3 addr=0 data=0 we=1111",
               z_cyc, z_addr, z_data, z_we);
    end
    checks++;
    if (done_cyc !== 4 || done_n !== 1) begin
      errors++; $display("FAIL empty_done: got cyc=%0d n=%0d required cyc=4 n=1", done_cyc, done_n);
    end
    checks++;
    if (busy_n !== 3) begin
      errors++; $display("FAIL empty_busy: got %0d busy cycles required 3", busy_n);
    end
  endtask

  task automatic test_single();
    stim = '{16'd5};
    run_and_capture(100, -1);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 32'h10 || got_we[0] !== 4'b1100) begin
      errors++;
      $display("FAIL single_write: got n=%0d addr=%0h we=%b required n=1 addr=10 we=1100",
               got_addr.size(), got_addr.size() > 0 ? got_addr[0] : 32'hx,
               got_we.size() > 0 ? got_we[0] : 4'hx);
    end
    checks++;
    if (outlier_count !== 32'd1 || z_data !== 32'd1) begin
      errors++; $display("FAIL single_count: got cnt=%0d z=%0d required 1", outlier_count, z_data);
    end
    checks++;
    if (done_cyc !== 5) begin
      errors++; $display("FAIL single_done: got cyc=%0d required 5", done_cyc);
    end
  endtask

  task automatic test_coalesce();
    logic [31:0] ea[$];
    logic [3:0]  ew[$];
    stim = '{16'd6, 16'd7, 16'd9};
    if (COAL) begin
      ea = '{32'h14, 32'h18};          ew = '{4'b1111, 4'b1100};
    end else begin
      ea = '{32'h14, 32'h14, 32'h18};  ew = '{4'b0011, 4'b1100, 4'b1100};
    end
    run_and_capture(100, -1);
    checks++;
    if (got_addr.size() != ea.size()) begin
      errors++; $display("FAIL coalesce_nwrites: got %0d required %0d", got_addr.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== ea[i] || got_we[i] !== ew[i]) begin
        errors++;
        $display("FAIL coalesce_write%0d: got addr=%0h we=%b required addr=%0h we=%b",
                 i, got_addr[i], got_we[i], ea[i], ew[i]);
      end
    end
    checks++;
    if (outlier_count !== 32'd3 || z_data !== 32'd3) begin
      errors++; $display("FAIL coalesce_count: got cnt=%0d z=%0d required 3", outlier_count, z_data);
    end
  endtask

  task automatic test_reject();
    stim = '{16'd0, 16'd150, 16'd3};
    run_and_capture(100, -1);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 32'h0C || got_we[0] !== 4'b1100) begin
      errors++;
      $display("FAIL reject_write: got n=%0d addr=%0h we=%b required n=1 addr=c we=1100",
               got_addr.size(), got_addr.size() > 0 ? got_addr[0] : 32'hx,
               got_we.size() > 0 ? got_we[0] : 4'hx);
    end
    checks++;
    if (outlier_count !== 32'd1 || z_data !== 32'd1) begin
      errors++; $display("FAIL reject_count: got cnt=%0d z=%0d required 1", outlier_count, z_data);
    end
    checks++;
    if (done_cyc !== 7) begin
      errors++; $display("FAIL reject_done: got cyc=%0d required 7", done_cyc);
    end
  endtask

  task automatic test_restart_ignored();
    stim = '{16'd6, 16'd7, 16'd9};
    run_and_capture(100, 2);
    checks++;
    if (done_n !== 1 || done_cyc !== 7) begin
      errors++; $display("FAIL restart_done: got n=%0d cyc=%0d required n=1 cyc=7", done_n, done_cyc);
    end
    checks++;
    if (outlier_count !== 32'd3 || z_n !== 1) begin
      errors++; $display("FAIL restart_count: got cnt=%0d zwrites=%0d required 3 and 1", outlier_count, z_n);
    end
  endtask

  task automatic test_reset_midrun();
    stim = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10};
    fifo_q = stim;
    refresh_fifo();
    point_cloud_size = 32'd100;
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;     // cycle 1: first pop
    @(posedge clock); #1;                   // cycle 2: second pop
    @(posedge clock); #2;                   // cycle 3
    checks++;
    if (outlier_count !== 32'd2 || en_x !== 1'b1) begin
      errors++; $display("FAIL midrun_state: got cnt=%0d en_x=%b required cnt=2 en_x=1", outlier_count, en_x);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd, addr_x, write_in_x, en_x, we_x, addr_z, write_in_z, en_z, we_z,
         busy, done, outlier_count} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got busy=%b en_x=%b rd=%b cnt=%0d, all zero required",
               busy, en_x, fifo_rd, outlier_count);
    end
    clear_logs();
    start_cyc = cyc;
    capturing = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    fifo_q.delete();
    refresh_fifo();
    reset_n = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    capturing = 1'b0;
    checks++;
    if (got_addr.size() != 0 || z_n != 0 || done_n != 0) begin
      errors++;
      $display("FAIL midrun_no_writes: got x=%0d z=%0d done=%0d required 0",
               got_addr.size(), z_n, done_n);
    end
    stim = '{16'd5};
    run_and_capture(100, -1);
    checks++;
    if (outlier_count !== 32'd1 || z_data !== 32'd1 || got_addr.size() != 1 || done_cyc !== 5) begin
      errors++;
      $display("FAIL midrun_rerun: got cnt=%0d z=%0d nx=%0d done=%0d required 1 1 1 5",
               outlier_count, z_data, got_addr.size(), done_cyc);
    end
  endtask

  task automatic test_random();
    int size, len, base, r;
    for (int it = 0; it < 25; it++) begin
      size = $urandom_range(10, 120);
      len  = $urandom_range(0, 10);
      base = $urandom_range(1, size);
      stim.delete();
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      stim.push_back(16'd0);
        else if (r == 1) stim.push_back(16'(size + $urandom_range(0, 20)));
        else if (r < 7) begin
          stim.push_back(16'(base + $urandom_range(0, 2)));
          if ($urandom_range(0, 2) == 0) base = base + 2;
        end else         stim.push_back(16'($urandom_range(1, size + 1)));
      end
      model(size);
      run_and_capture(size, -1);
      checks++;
      if (outlier_count !== 32'(exp_count) || z_data !== 32'(exp_count)) begin
        errors++;
        $display("FAIL rand%0d_count: got cnt=%0d z=%0d required %0d", it, outlier_count, z_data, exp_count);
      end
      checks++;
      if (got_addr.size() != exp_addr.size() || wdata_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_nwrites: got %0d (bad data %0d) required %0d", it,
                 got_addr.size(), wdata_bad, exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_we[i] !== exp_we[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got addr=%0h we=%b required addr=%0h we=%b",
                   it, i, got_addr[i], got_we[i], exp_addr[i], exp_we[i]);
        end
      end
      checks++;
      if (done_cyc !== 4 + len || done_n !== 1 || busy_n !== 3 + len) begin
        errors++;
        $display("FAIL rand%0d_timing: got done=%0d n=%0d busy=%0d required done=%0d n=1 busy=%0d",
                 it, done_cyc, done_n, busy_n, 4 + len, 3 + len);
      end
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_empty();
    test_single();
    test_coalesce();
    test_reject();
    test_restart_ignored();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
